multi_rate_tick_gen: RTL and testbench
======================================

# multi_rate_tick_gen

Parametrised multi-rate timebase that replaces the free-running per-unit bench clocks (sqrt, fp, int) with clock-enable ticks derived from the single system clock `clk`. Each of `NUM_CH` channels divides `clk` by a runtime-programmable ratio and produces a one-cycle `tick` strobe plus a 50%-duty `phase` square wave. Channels have individual enables, glitch-free ratio updates that take effect at a period boundary, and a global phase-realign command. It sits at the top of the CPU, feeding clock enables to the multi-cycle execution units.

## Interface
- `NUM_CH`, 4, number of channels (≥1)
- `DIV_W`, 16, width of divide ratio
- `RESET_DIV`, 1, ratio loaded into every channel at reset (1..2^DIV_W-1)
- `CH_W`, derived `max(1,$clog2(NUM_CH))`, channel index width (not overridable)
- `clk` in 1: sole clock; all state updates on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `cfg_we` in 1: ratio write strobe
- `cfg_ch` in CH_W: target channel of write
- `cfg_div` in DIV_W: new ratio; 0 = stop channel
- `sync_all` in 1: realign all channels, one-cycle pulse
- `ch_en` in NUM_CH: per-channel run enable (level)
- `tick` out NUM_CH: registered one-cycle strobe per period
- `phase` out NUM_CH: registered divided clock, period 2·div
- `cfg_err` out 1: registered one-cycle pulse on invalid `cfg_ch`

## Operation
- Per channel state: `div` (active ratio), `shadow` + `pend` flag, down-counter `cnt` (DIV_W bits), `tick`, `phase`.
- Reset (async, `rst_n`=0): `div`=RESET_DIV, `cnt`=RESET_DIV-1, `pend`=0, `tick`=0, `phase`=0, `cfg_err`=0.
- Running (`ch_en`=1, `div`≠0): each edge, if `cnt`≠0 then `cnt`-1, `tick`←0; if `cnt`=0 then `tick`←1, `phase` toggles, `cnt`←(`pend`?`shadow`:`div`)-1, and if `pend` then `div`←`shadow`, `pend`←0.
- Paused (`ch_en`=0): `cnt`, `phase`, `div` hold; `tick`←0. Pending write stays pending.
- Stopped (`div`=0): `tick`←0, `cnt`, `phase` hold regardless of `ch_en`.
- Write (`cfg_we`=1, `cfg_ch`<NUM_CH): if target `div`=0, apply immediately: `div`←`cfg_div`, `cnt`←`cfg_div`-1, `pend`←0. Otherwise `shadow`←`cfg_div`, `pend`←1; applied at next wrap. Repeated writes before wrap: last wins. Writing 0 to a running channel stops it at next wrap (that wrap's tick still fires).
- `cfg_ch`≥NUM_CH: write ignored, `cfg_err`←1 next cycle, else `cfg_err`←0.
- `sync_all`=1: every channel: if `pend` then `div`←`shadow`, `pend`←0; `cnt`←new `div`-1 (0 if `div`=0); `phase`←0; `tick`←0. Overrides wrap and pause in that cycle. A same-cycle valid `cfg_we` is folded in first (new value applied by the sync).

## Timing
- Ratio D: `tick` high exactly 1 cycle in every D enabled cycles; D=1 → `tick` constantly 1 while enabled.
- After reset release with `ch_en`=1: first `tick` high in cycle following the D-th rising edge.
- `phase` changes on the same edge `tick` rises; period 2·D, high D cycles.
- Latency `cfg_we` → effect: immediate (stopped channel, next edge) or next wrap (running).
- `cfg_err` latency 1 cycle; `sync_all` effect visible 1 edge later, first post-sync tick D edges after the sync edge.
- Reset mid-period: outputs drop to reset values asynchronously, no partial tick.

## Structure
- Package `tick_gen_pkg`: `CH_W` computation function, `div_t` typedef (DIV_W-wide, parameterised via module), channel-state struct.
- Sub-module `tick_channel` (one instance per channel via generate): holds `div/shadow/pend/cnt/tick/phase`; top decodes `cfg_ch`, fans out `sync_all`, drives `cfg_err`.

## Test plan
- Reset, RESET_DIV=1, all `ch_en`=1 → all `tick`=1 every cycle, `phase` toggles each cycle.
- Write ch0 div=4 after setting it to 0 → tick on edges 4,8,12 after write; `phase` period 8.
- Ch1 running div=5, write 3 at cnt=2 then write 7 → two more cycles at 5, wrap ticks, then period 7 (3 discarded).
- Ch2 div=6, drop `ch_en` for 10 cycles mid-count → no ticks, count resumes where held; total tick spacing 16.
- Channels div 2,3,5,7 free-running, pulse `sync_all` → all `phase`=0 next cycle, ticks at edges 2,3,5,7 after sync, coincident tick on all at edge 210.
- `cfg_we` with `cfg_ch`=NUM_CH (NUM_CH=3) → `cfg_err` one-cycle pulse, no channel state change; assert `rst_n`=0 mid-period → `tick`,`phase` zero immediately.

Source files
------------

// File: rtl/multi_rate_tick_gen_pkg.sv
// Shared definitions for the multi-rate tick generator: channel index width
// helper and the per-channel flag state.
package tick_gen_pkg;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic pend;
    logic tick;
    logic phase;
  } ch_flags_t;

endpackage

// File: rtl/multi_rate_tick_gen_channel.sv
// One divider channel: down-counter with shadowed ratio, emits a one-cycle
// tick and a 50% phase wave per period.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int RESET_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             we,
  input  logic [DIV_W-1:0] wdiv,
  input  logic             sync,
  output logic             tick,
  output logic             phase
);

  typedef logic [DIV_W-1:0] div_t;

  div_t      div, shadow, cnt, sync_div;
  ch_flags_t st;

  function automatic div_t reload(input div_t d);
    return (d == '0) ? '0 : d - div_t'(1);
  endfunction

  // A write in the sync cycle is folded in, so it always becomes the new ratio.
  always_comb sync_div = we ? wdiv : (st.pend ? shadow : div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= div_t'(RESET_DIV);
      cnt    <= div_t'(RESET_DIV - 1);
      shadow <= '0;
      st     <= '0;
    end else if (sync) begin
      div      <= sync_div;
      cnt      <= reload(sync_div);
      st       <= '0;
    end else if (we && div == '0) begin
      div      <= wdiv;
      cnt      <= reload(wdiv);
      st.pend  <= 1'b0;
      st.tick  <= 1'b0;
    end else begin
      st.tick <= 1'b0;
      if (en && div != '0) begin
        if (cnt != '0) begin
          cnt <= cnt - div_t'(1);
        end else begin
          st.tick  <= 1'b1;
          st.phase <= ~st.phase;
          cnt      <= reload(st.pend ? shadow : div);
          if (st.pend) begin
            div     <= shadow;
            st.pend <= 1'b0;
          end
        end
      end
      // Placed after the wrap so a write on the wrap edge stays pending.
      if (we) begin
        shadow  <= wdiv;
        st.pend <= 1'b1;
      end
    end
  end

  assign tick  = st.tick;
  assign phase = st.phase;

endmodule

// File: rtl/multi_rate_tick_gen.sv
// Multi-rate timebase: NUM_CH programmable clock-enable tick channels,
// config write decode and invalid-channel error flag.
module multi_rate_tick_gen
  import tick_gen_pkg::*;
#(
  parameter int  NUM_CH    = 4,
  parameter int  DIV_W     = 16,
  parameter int  RESET_DIV = 1,
  localparam int CH_W      = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              sync_all,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] phase,
  output logic              cfg_err
);

  logic ch_bad;
  assign ch_bad = int'(cfg_ch) >= NUM_CH;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_channel #(
      .DIV_W     (DIV_W),
      .RESET_DIV (RESET_DIV)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ch_en[i]),
      .we    (cfg_we && cfg_ch == CH_W'(i)),
      .wdiv  (cfg_div),
      .sync  (sync_all),
      .tick  (tick[i]),
      .phase (phase[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= cfg_we && ch_bad;
  end

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// Scoreboard bench: stimulus pushes model-predicted outputs, a negedge
// monitor pops and compares them against the DUT.
module tb_multi_rate_tick_gen;
  localparam int NCH = 3;
  localparam int DW  = 8;

  logic           clk = 0;
  logic           rst_n = 0;
  logic           cfg_we = 0;
  logic [1:0]     cfg_ch = 0;
  logic [DW-1:0]  cfg_div = 0;
  logic           sync_all = 0;
  logic [NCH-1:0] ch_en = '1;
  logic [NCH-1:0] tick, phase;
  logic           cfg_err;

  multi_rate_tick_gen #(.NUM_CH(NCH), .DIV_W(DW), .RESET_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .sync_all(sync_all), .ch_en(ch_en),
    .tick(tick), .phase(phase), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: ratio, pending ratio, enabled cycles elapsed in current period.
  int m_div[NCH], m_sh[NCH], m_pos[NCH];
  bit m_pend[NCH], m_tk[NCH], m_ph[NCH];
  bit m_err;
  logic [2*NCH:0] expq[$];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_div[c] = 1; m_sh[c] = 0; m_pos[c] = 0;
      m_pend[c] = 0; m_tk[c] = 0; m_ph[c] = 0;
    end
    m_err = 0;
  endtask

  task automatic model_edge();
    logic [2*NCH:0] e;
    m_err = cfg_we && (cfg_ch >= NCH);
    for (int c = 0; c < NCH; c++) begin
      bit w;
      w = cfg_we && (cfg_ch == c);
      if (sync_all) begin
        if (w) m_div[c] = cfg_div;
        else if (m_pend[c]) m_div[c] = m_sh[c];
        m_pend[c] = 0; m_pos[c] = 0; m_ph[c] = 0; m_tk[c] = 0;
      end else if (w && m_div[c] == 0) begin
        m_div[c] = cfg_div; m_pos[c] = 0; m_pend[c] = 0; m_tk[c] = 0;
      end else begin
        m_tk[c] = 0;
        if (ch_en[c] && m_div[c] != 0) begin
          m_pos[c]++;
          if (m_pos[c] == m_div[c]) begin
            m_tk[c] = 1; m_ph[c] = !m_ph[c]; m_pos[c] = 0;
            if (m_pend[c]) begin m_div[c] = m_sh[c]; m_pend[c] = 0; end
          end
        end
        if (w) begin m_sh[c] = cfg_div; m_pend[c] = 1; end
      end
    end
    e[2*NCH] = m_err;
    for (int c = 0; c < NCH; c++) begin
      e[c] = m_tk[c];
      e[NCH+c] = m_ph[c];
    end
    expq.push_back(e);
  endtask

  task automatic cyc(input bit we, input int ch, input int dv, input bit sy,
                     input logic [NCH-1:0] en);
    cfg_we = we; cfg_ch = ch[1:0]; cfg_div = dv[DW-1:0];
    sync_all = sy; ch_en = en;
    @(posedge clk);
    model_edge();
    #1;
    cfg_we = 0; sync_all = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n && expq.size() > 0) begin
      logic [2*NCH:0] e, a;
      e = expq.pop_front();
      a = {cfg_err, phase, tick};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs t=%0t got {err,phase,tick}=%b want %b", $time, a, e);
      end
    end
  end

  task automatic check_reset(input string nm);
    total++;
    if ({cfg_err, phase, tick} !== '0) begin
      bad++;
      $display("FAIL %s got %b want 0", nm, {cfg_err, phase, tick});
    end
  endtask

  initial begin
    model_reset();
    #12 check_reset("reset_state");
    @(posedge clk); #1 rst_n = 1;

    // RESET_DIV=1: every channel ticks every cycle
    repeat (8) cyc(0, 0, 0, 0, '1);

    // stop ch0, then program 4 while stopped
    cyc(1, 0, 0, 0, '1);
    repeat (3) cyc(0, 0, 0, 0, '1);
    cyc(1, 0, 4, 0, '1);
    repeat (20) cyc(0, 0, 0, 0, '1);

    // ch1 ratio 5, then back-to-back writes 3 then 7: last wins
    cyc(1, 1, 5, 0, '1);
    repeat (12) cyc(0, 0, 0, 0, '1);
    cyc(1, 1, 3, 0, '1);
    cyc(1, 1, 7, 0, '1);
    repeat (20) cyc(0, 0, 0, 0, '1);

    // ch2 ratio 6 with a 10-cycle pause mid-count
    cyc(1, 2, 6, 0, '1);
    repeat (9) cyc(0, 0, 0, 0, '1);
    repeat (10) cyc(0, 0, 0, 0, 3'b011);
    repeat (20) cyc(0, 0, 0, 0, '1);

    // ratios 2,3,5 then sync; coincident tick after 30 cycles
    cyc(1, 0, 2, 0, '1);
    cyc(1, 1, 3, 0, '1);
    cyc(1, 2, 5, 0, '1);
    repeat (7) cyc(0, 0, 0, 0, '1);
    cyc(0, 0, 0, 1, '1);
    repeat (35) cyc(0, 0, 0, 0, '1);

    // invalid channel index, plus a write folded into a sync
    cyc(1, 3, 9, 0, '1);
    repeat (5) cyc(0, 0, 0, 0, '1);
    cyc(1, 1, 4, 1, '1);
    repeat (10) cyc(0, 0, 0, 0, '1);

    // randomized traffic
    repeat (3000) begin
      bit we, sy;
      we = ($urandom_range(0, 7) == 0);
      sy = ($urandom_range(0, 99) == 0);
      cyc(we, $urandom_range(0, 3), $urandom_range(0, 7), sy,
          ($urandom_range(0, 9) == 0) ? NCH'($urandom) : '1);
    end

    // asynchronous reset mid-period
    @(posedge clk); #2;
    expq.delete();
    rst_n = 0;
    #1 check_reset("async_reset");
    model_reset();
    @(posedge clk); #1 rst_n = 1;
    repeat (500) begin
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 3),
          $urandom_range(0, 9), $urandom_range(0, 49) == 0,
          NCH'($urandom) | 3'b001);
    end
    @(negedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
